// File: rtl/aud_rec_if.sv
// Bundles the control pulses, I2S ADC inputs, SRAM write port and status of the audio recorder.
interface aud_rec_if;
    logic        i_start;
    logic        i_pause;
    logic        i_stop;
    logic        i_adclrck;
    logic        i_adcdat;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_data;
    logic        o_sram_we_n;
    logic [19:0] o_rec_len;
    logic        o_full;
    logic        o_busy;

    modport master (
        output i_start, i_pause, i_stop, i_adclrck, i_adcdat,
        input  o_sram_addr, o_sram_data, o_sram_we_n, o_rec_len, o_full, o_busy
    );

    modport slave (
        input  i_start, i_pause, i_stop, i_adclrck, i_adcdat,
        output o_sram_addr, o_sram_data, o_sram_we_n, o_rec_len, o_full, o_busy
    );
endinterface

// File: rtl/aud_rec_writer.sv
// Captures 16-bit left-channel I2S ADC samples and writes them to consecutive SRAM addresses.
//
// state    | meaning
// IDLE     | not recording; address/length/full hold
// WAIT_LRC | waiting for the left-frame edge (falling LRCK)
// SHIFT    | shifting in 16 data bits, MSB first
// WRITE    | one-cycle SRAM write of the assembled sample
// PAUSE    | recording suspended; address/length hold
module aud_rec_writer (
    input  logic      i_clk,
    input  logic      i_rst_n,
    aud_rec_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_LRC = 3'd1,
        SHIFT    = 3'd2,
        WRITE    = 3'd3,
        PAUSE    = 3'd4
    } state_t;

    state_t      state, state_d;
    logic        lrc_d;
    logic [14:0] shreg, shreg_d;
    logic [3:0]  bit_cnt, cnt_d;
    logic [15:0] data_q, data_d;
    logic [19:0] addr_q, addr_d;
    logic [19:0] len_q, len_d;
    logic        full_q, full_d;
    logic        lfe;

    assign lfe = lrc_d & ~bus.i_adclrck;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            lrc_d   <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state   <= state_d;
            lrc_d   <= bus.i_adclrck;
            shreg   <= shreg_d;
            bit_cnt <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = bit_cnt;
        data_d  = data_q;
        addr_d  = addr_q;
        len_d   = len_q;
        full_d  = full_q;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    addr_d  = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                    state_d = WAIT_LRC;
                end
            end
            WAIT_LRC: begin
                // The LFE cycle itself is the I2S one-bit delay slot, so its data is skipped.
                if (bus.i_stop)       state_d = IDLE;
                else if (bus.i_pause) state_d = PAUSE;
                else if (lfe) begin
                    cnt_d   = 4'd15;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = {shreg[13:0], bus.i_adcdat};
                if (bus.i_stop)       state_d = IDLE;
                else if (bus.i_pause) state_d = PAUSE;
                else if (bit_cnt == 4'd0) begin
                    data_d  = {shreg, bus.i_adcdat};
                    state_d = WRITE;
                end else begin
                    cnt_d = bit_cnt - 4'd1;
                end
            end
            WRITE: begin
                len_d = len_q + 20'd1;
                if (addr_q == 20'hFFFFF) begin
                    full_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 20'd1;
                    if (bus.i_stop)       state_d = IDLE;
                    else if (bus.i_pause) state_d = PAUSE;
                    else                  state_d = WAIT_LRC;
                end
            end
            PAUSE: begin
                if (bus.i_stop)       state_d = IDLE;
                else if (bus.i_start) state_d = WAIT_LRC;
            end
            default: state_d = IDLE;
        endcase
    end

    // we_n decodes straight from state so an async reset deasserts it immediately.
    assign bus.o_sram_we_n = (state != WRITE);
    assign bus.o_sram_addr = addr_q;
    assign bus.o_sram_data = data_q;
    assign bus.o_rec_len   = len_q;
    assign bus.o_full      = full_q;
    assign bus.o_busy      = (state != IDLE);
endmodule

// File: tb/tb_aud_rec_writer.sv
// Self-checking bench for aud_rec_writer: table-driven frames plus corner-case sequences,
// with SRAM writes compared against a scoreboard queue.
module tb_aud_rec_writer;
    logic clk;
    logic rst_n;
    aud_rec_if bus ();

    aud_rec_writer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [19:0] exp_addr;
        logic [19:0] exp_len;
    } vec_t;

    vec_t        vecs [5];
    logic [35:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every we_n low cycle must match the oldest expected write.
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && bus.o_sram_we_n === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.o_sram_addr, bus.o_sram_data);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(bus.o_sram_addr), 32'(e[35:16]));
                chk("wr_data", 32'(bus.o_sram_data), 32'(e[15:0]));
            end
        end
    end

    task automatic pulse(input logic st, input logic pa, input logic sp);
        @(negedge clk);
        bus.i_start = st;
        bus.i_pause = pa;
        bus.i_stop  = sp;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_stop  = 1'b0;
    endtask

    // One 40-cycle LRCK frame (20 left, 20 right). act = {rst, stop, pause, start} applied at cycle act_at.
    task automatic send_frame(input logic [15:0] d, input int act_at, input logic [3:0] act,
                              input bit chk_t, input logic [19:0] base);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (chk_t) begin
                if (k == 16) chk("t_we_before", 32'(bus.o_sram_we_n), 32'd1);
                if (k == 17) begin
                    chk("t_we_low", 32'(bus.o_sram_we_n), 32'd0);
                    chk("t_addr_during", 32'(bus.o_sram_addr), 32'(base));
                end
                if (k == 18) begin
                    chk("t_we_after", 32'(bus.o_sram_we_n), 32'd1);
                    chk("t_addr_inc", 32'(bus.o_sram_addr), 32'(base) + 1);
                end
            end
            bus.i_start   = 1'b0;
            bus.i_pause   = 1'b0;
            bus.i_stop    = 1'b0;
            bus.i_adclrck = (k >= 20);
            if (k == 0)                 bus.i_adcdat = ~d[15];
            else if (k >= 1 && k <= 16) bus.i_adcdat = d[16-k];
            else                        bus.i_adcdat = 1'($urandom_range(0, 1));
            if (k == act_at) begin
                bus.i_stop  = act[2];
                bus.i_pause = act[1];
                bus.i_start = act[0];
                if (act[3]) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_we_async", 32'(bus.o_sram_we_n), 32'd1);
                    chk("rst_addr", 32'(bus.o_sram_addr), 32'd0);
                    chk("rst_data", 32'(bus.o_sram_data), 32'd0);
                    chk("rst_len", 32'(bus.o_rec_len), 32'd0);
                    chk("rst_full", 32'(bus.o_full), 32'd0);
                    chk("rst_busy", 32'(bus.o_busy), 32'd0);
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 20'd0, 20'd1};
        vecs[1] = '{16'h1234, 20'd1, 20'd2};
        vecs[2] = '{16'hFFFF, 20'd2, 20'd3};
        vecs[3] = '{16'h0000, 20'd3, 20'd4};
        vecs[4] = '{16'h8001, 20'd4, 20'd5};

        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_pause   = 1'b0;
        bus.i_stop    = 1'b0;
        bus.i_adclrck = 1'b1;
        bus.i_adcdat  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_addr", 32'(bus.o_sram_addr), 32'd0);
        chk("reset_data", 32'(bus.o_sram_data), 32'd0);
        chk("reset_we_n", 32'(bus.o_sram_we_n), 32'd1);
        chk("reset_len", 32'(bus.o_rec_len), 32'd0);
        chk("reset_full", 32'(bus.o_full), 32'd0);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;

        // Pause and stop are ignored while idle.
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("idle_ignore_busy", 32'(bus.o_busy), 32'd0);

        // Basic table-driven recording.
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_busy", 32'(bus.o_busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back({vecs[i].exp_addr, vecs[i].data});
            send_frame(vecs[i].data, -1, 4'b0000, i == 0, vecs[i].exp_addr);
            chk("tbl_len", 32'(bus.o_rec_len), 32'(vecs[i].exp_len));
            chk("tbl_addr", 32'(bus.o_sram_addr), 32'(vecs[i].exp_addr) + 1);
        end

        // Start during SHIFT is ignored.
        sb_q.push_back({20'd5, 16'h5A5A});
        send_frame(16'h5A5A, 6, 4'b0001, 1'b0, 20'd0);
        chk("start_in_shift_len", 32'(bus.o_rec_len), 32'd6);

        // Pause during WRITE: write completes, then PAUSE.
        sb_q.push_back({20'd6, 16'h0F0F});
        send_frame(16'h0F0F, 17, 4'b0010, 1'b0, 20'd0);
        chk("pause_wr_busy", 32'(bus.o_busy), 32'd1);
        chk("pause_wr_len", 32'(bus.o_rec_len), 32'd7);
        chk("pause_wr_addr", 32'(bus.o_sram_addr), 32'd7);
        send_frame(16'h1111, -1, 4'b0000, 1'b0, 20'd0);
        chk("paused_len_hold", 32'(bus.o_rec_len), 32'd7);
        pulse(1'b1, 1'b0, 1'b0);

        // Stop during WRITE: write completes and is counted.
        sb_q.push_back({20'd7, 16'hC0DE});
        send_frame(16'hC0DE, 17, 4'b0100, 1'b0, 20'd0);
        chk("stop_wr_busy", 32'(bus.o_busy), 32'd0);
        chk("stop_wr_len", 32'(bus.o_rec_len), 32'd8);
        chk("stop_wr_addr", 32'(bus.o_sram_addr), 32'd8);
        send_frame(16'h4444, -1, 4'b0000, 1'b0, 20'd0);
        chk("idle_len_hold", 32'(bus.o_rec_len), 32'd8);

        // Pause at bit 8 of frame 2, then resume.
        pulse(1'b1, 1'b0, 1'b0);
        chk("restart_addr", 32'(bus.o_sram_addr), 32'd0);
        chk("restart_len", 32'(bus.o_rec_len), 32'd0);
        sb_q.push_back({20'd0, 16'hA5C3});
        send_frame(16'hA5C3, -1, 4'b0000, 1'b0, 20'd0);
        send_frame(16'h1234, 8, 4'b0010, 1'b0, 20'd0);
        chk("pause_len", 32'(bus.o_rec_len), 32'd1);
        chk("pause_addr", 32'(bus.o_sram_addr), 32'd1);
        chk("pause_busy", 32'(bus.o_busy), 32'd1);
        send_frame(16'h7777, -1, 4'b0000, 1'b0, 20'd0);
        pulse(1'b1, 1'b0, 1'b0);
        sb_q.push_back({20'd1, 16'hBEEF});
        send_frame(16'hBEEF, -1, 4'b0000, 1'b1, 20'd1);
        chk("resume_len", 32'(bus.o_rec_len), 32'd2);

        // Stop and pause together during SHIFT: stop wins.
        send_frame(16'h2222, 5, 4'b0110, 1'b0, 20'd0);
        chk("prio_busy", 32'(bus.o_busy), 32'd0);
        chk("prio_len", 32'(bus.o_rec_len), 32'd2);
        chk("prio_addr", 32'(bus.o_sram_addr), 32'd2);

        // Address space exhaustion.
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        force dut.addr_q = 20'hFFFFE;
        @(negedge clk);
        release dut.addr_q;
        @(negedge clk);
        chk("full_preset_addr", 32'(bus.o_sram_addr), 32'hFFFFE);
        sb_q.push_back({20'hFFFFE, 16'h1357});
        sb_q.push_back({20'hFFFFF, 16'h2468});
        send_frame(16'h1357, -1, 4'b0000, 1'b0, 20'd0);
        send_frame(16'h2468, -1, 4'b0000, 1'b0, 20'd0);
        chk("full_flag", 32'(bus.o_full), 32'd1);
        chk("full_busy", 32'(bus.o_busy), 32'd0);
        chk("full_addr", 32'(bus.o_sram_addr), 32'hFFFFF);
        chk("full_len", 32'(bus.o_rec_len), 32'd2);
        send_frame(16'h3333, -1, 4'b0000, 1'b0, 20'd0);
        chk("full_addr_hold", 32'(bus.o_sram_addr), 32'hFFFFF);
        pulse(1'b1, 1'b0, 1'b0);
        chk("full_clear", 32'(bus.o_full), 32'd0);
        chk("full_restart_addr", 32'(bus.o_sram_addr), 32'd0);
        pulse(1'b0, 1'b0, 1'b1);

        // Reset asserted mid-WRITE.
        pulse(1'b1, 1'b0, 1'b0);
        sb_q.push_back({20'd0, 16'h9ABC});
        send_frame(16'h9ABC, 17, 4'b1000, 1'b0, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_len", 32'(bus.o_rec_len), 32'd0);
        chk("post_rst_busy", 32'(bus.o_busy), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
